// File: rtl/dram_ring_scheduler.sv
// Wishbone sequencer for the DDR3 wrapper port, shared between a write producer and a read
// consumer. The DRAM region [BASE_ADDR, BASE_ADDR+RING_WORDS-1] is used as a circular buffer.
// One transaction is outstanding at a time. Simultaneous requests are arbitrated round-robin.
// Optional feature: define DRAM_RING_SCHED_TIMEOUT_EN to abort a bus cycle that receives no
// ack within TIMEOUT_CYCLES cycles; err_o pulses on abort and stays 0 without the macro.
module dram_ring_scheduler #(
  parameter int unsigned WORD_SIZE      = 256,
  parameter int unsigned ADDR_WIDTH     = 25,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned RING_WORDS     = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          initialized_i,
  input  logic                          wr_req_i,
  input  logic [WORD_SIZE-1:0]          wr_data_i,
  output logic                          wr_done_o,
  input  logic                          rd_req_i,
  output logic [WORD_SIZE-1:0]          rd_data_o,
  output logic                          rd_valid_o,
  output logic                          cyc_o,
  output logic                          stb_o,
  output logic                          we_o,
  output logic [31:0]                   addr_o,
  output logic [WORD_SIZE-1:0]          data_o,
  input  logic [WORD_SIZE-1:0]          data_i,
  input  logic                          ack_i,
  output logic [$clog2(RING_WORDS):0]   level_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic                          err_o
);

  localparam int unsigned PtrW   = $clog2(RING_WORDS);
  localparam int unsigned LevelW = PtrW + 1;

  // Reject configurations the pointer arithmetic cannot handle.
  if ((RING_WORDS < 2) || ((RING_WORDS & (RING_WORDS - 1)) != 0)) begin : g_bad_ring
    $error("RING_WORDS must be a power of two and at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    StInitWait,
    StIdle,
    StBus,
    StDone
  } state_e;

  state_e              state_q;
  logic [PtrW-1:0]     wr_ptr_q;
  logic [PtrW-1:0]     rd_ptr_q;
  // 1: last grant went to the read side, so a tie goes to the writer.
  logic                last_grant_rd_q;

`ifdef DRAM_RING_SCHED_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TmoW-1:0]     tmo_cnt_q;
`endif

  logic                  wr_elig;
  logic                  rd_elig;
  logic                  grant_wr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // full_o/empty_o are registered copies of the level comparison, so eligibility uses them.
  assign wr_elig  = wr_req_i && !full_o;
  assign rd_elig  = rd_req_i && !empty_o;
  assign grant_wr = wr_elig && (!rd_elig || last_grant_rd_q);

  // Pointers stay inside the ring because PtrW wraps naturally at RING_WORDS.
  assign wr_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(wr_ptr_q);
  assign rd_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(rd_ptr_q);

  // Control FSM with registered bus, status and pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StInitWait;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      last_grant_rd_q <= 1'b1;
      level_o         <= '0;
      full_o          <= 1'b0;
      empty_o         <= 1'b1;
      cyc_o           <= 1'b0;
      stb_o           <= 1'b0;
      we_o            <= 1'b0;
      addr_o          <= '0;
      data_o          <= '0;
      rd_data_o       <= '0;
      wr_done_o       <= 1'b0;
      rd_valid_o      <= 1'b0;
      err_o           <= 1'b0;
`ifdef DRAM_RING_SCHED_TIMEOUT_EN
      tmo_cnt_q       <= '0;
`endif
    end else begin
      wr_done_o  <= 1'b0;
      rd_valid_o <= 1'b0;
      err_o      <= 1'b0;
      unique case (state_q)
        StInitWait: begin
          if (initialized_i) state_q <= StIdle;
        end
        StIdle: begin
          if (!initialized_i) begin
            state_q <= StInitWait;
          end else if (wr_elig || rd_elig) begin
            cyc_o           <= 1'b1;
            stb_o           <= 1'b1;
            we_o            <= grant_wr;
            addr_o          <= 32'(grant_wr ? wr_addr : rd_addr);
            if (grant_wr) data_o <= wr_data_i;
            last_grant_rd_q <= !grant_wr;
            state_q         <= StBus;
`ifdef DRAM_RING_SCHED_TIMEOUT_EN
            tmo_cnt_q       <= '0;
`endif
          end
        end
        StBus: begin
          if (ack_i) begin
            cyc_o   <= 1'b0;
            stb_o   <= 1'b0;
            state_q <= StDone;
            if (we_o) begin
              wr_ptr_q  <= wr_ptr_q + PtrW'(1);
              level_o   <= level_o + LevelW'(1);
              full_o    <= (level_o + LevelW'(1)) == LevelW'(RING_WORDS);
              empty_o   <= 1'b0;
              wr_done_o <= 1'b1;
            end else begin
              rd_data_o  <= data_i;
              rd_ptr_q   <= rd_ptr_q + PtrW'(1);
              level_o    <= level_o - LevelW'(1);
              full_o     <= 1'b0;
              empty_o    <= level_o == LevelW'(1);
              rd_valid_o <= 1'b1;
            end
          end
`ifdef DRAM_RING_SCHED_TIMEOUT_EN
          // Abort leaves pointers and level alone; the request is retried from IDLE.
          else if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
            cyc_o   <= 1'b0;
            stb_o   <= 1'b0;
            err_o   <= 1'b1;
            state_q <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
          end
`endif
        end
        StDone: begin
          // Requests are ignored here so the requester can drop its request.
          state_q <= StIdle;
        end
        default: begin
          state_q <= StInitWait;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_ring_scheduler.sv
// Scoreboard bench for dram_ring_scheduler with a 4-word ring at word address 0x100.
// Stimulus pushes expected bus cycles and read data; a monitor pops them as the DUT presents them.
module tb_dram_ring_scheduler;

  localparam int unsigned WS   = 256;
  localparam int unsigned BASE = 32'h100;
  localparam int unsigned RW   = 4;
  localparam int          ACK_DLY = 4;

  typedef struct packed {
    logic          we;
    logic [31:0]   addr;
    logic [WS-1:0] data;
  } bus_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          initialized_i;
  logic          wr_req_i;
  logic [WS-1:0] wr_data_i;
  logic          wr_done_o;
  logic          rd_req_i;
  logic [WS-1:0] rd_data_o;
  logic          rd_valid_o;
  logic          cyc_o;
  logic          stb_o;
  logic          we_o;
  logic [31:0]   addr_o;
  logic [WS-1:0] data_o;
  logic [WS-1:0] data_i;
  logic          ack_i;
  logic [2:0]    level_o;
  logic          full_o;
  logic          empty_o;
  logic          err_o;

  int checks = 0;
  int errors = 0;
  int err_count = 0;
  bit no_ack = 1'b0;

  bus_t          bus_q[$];
  logic [WS-1:0] rd_q[$];
  logic [WS-1:0] mem [0:RW-1];

  localparam logic [WS-1:0] A1 = {8{32'hA1A1_0001}};
  localparam logic [WS-1:0] A2 = {8{32'hA2A2_0002}};
  localparam logic [WS-1:0] A3 = {8{32'hA3A3_0003}};
  localparam logic [WS-1:0] X0 = {8{32'hDEAD_BEEF}};
  localparam logic [WS-1:0] B0 = {8{32'hB0B0_0010}};
  localparam logic [WS-1:0] B1 = {8{32'hB1B1_0011}};
  localparam logic [WS-1:0] B2 = {8{32'hB2B2_0012}};
  localparam logic [WS-1:0] B3 = {8{32'hB3B3_0013}};
  localparam logic [WS-1:0] B4 = {8{32'hB4B4_0014}};
  localparam logic [WS-1:0] C0 = {8{32'hC0C0_0020}};
  localparam logic [WS-1:0] C1 = {8{32'hC1C1_0021}};
  localparam logic [WS-1:0] D0 = {8{32'hD0D0_0030}};
  localparam logic [WS-1:0] E0 = {8{32'hE0E0_0040}};

  dram_ring_scheduler #(
    .WORD_SIZE      (WS),
    .ADDR_WIDTH     (25),
    .BASE_ADDR      (BASE),
    .RING_WORDS     (RW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .initialized_i (initialized_i),
    .wr_req_i      (wr_req_i),
    .wr_data_i     (wr_data_i),
    .wr_done_o     (wr_done_o),
    .rd_req_i      (rd_req_i),
    .rd_data_o     (rd_data_o),
    .rd_valid_o    (rd_valid_o),
    .cyc_o         (cyc_o),
    .stb_o         (stb_o),
    .we_o          (we_o),
    .addr_o        (addr_o),
    .data_o        (data_o),
    .data_i        (data_i),
    .ack_i         (ack_i),
    .level_o       (level_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WS-1:0] got, input logic [WS-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic exp_bus(input logic we, input int unsigned idx, input logic [WS-1:0] d);
    bus_t e;
    e.we   = we;
    e.addr = BASE + idx;
    e.data = d;
    bus_q.push_back(e);
  endtask

  task automatic do_write(input logic [WS-1:0] d, input int bound);
    bit done = 1'b0;
    wr_data_i = d;
    wr_req_i  = 1'b1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (wr_done_o) begin
        done = 1'b1;
        break;
      end
    end
    wr_req_i = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wr_done_timeout got none exp pulse within %0d cycles", bound);
    end
  endtask

  task automatic do_read(input int bound);
    bit done = 1'b0;
    rd_req_i = 1'b1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (rd_valid_o) begin
        done = 1'b1;
        break;
      end
    end
    rd_req_i = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rd_valid_timeout got none exp pulse within %0d cycles", bound);
    end
  endtask

  // Wishbone slave: acks ACK_DLY cycles into a strobe unless no_ack is set.
  initial begin
    int cnt;
    logic [31:0] idx;
    ack_i  = 1'b0;
    data_i = '0;
    cnt    = 0;
    forever begin
      @(negedge clk);
      if (ack_i) begin
        ack_i = 1'b0;
        cnt   = 0;
      end else if (cyc_o && stb_o && !rst) begin
        cnt++;
        if (!no_ack && cnt >= ACK_DLY) begin
          ack_i = 1'b1;
          idx   = addr_o - BASE;
          if (we_o) mem[idx[1:0]] = data_o;
          else      data_i = mem[idx[1:0]];
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: checks each new bus cycle and each read pulse against the scoreboard.
  initial begin
    bit prev_stb = 1'b0;
    bit prev_pulse = 1'b0;
    bus_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (stb_o && !prev_stb) begin
          chk("grant_after_done_cycle", prev_pulse, 0);
          if (bus_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bus_cycle got addr %h we %b exp no cycle", addr_o, we_o);
          end else begin
            e = bus_q.pop_front();
            chk("bus_we", we_o, e.we);
            chk("bus_addr", addr_o, e.addr);
            if (e.we) chk("bus_wdata", data_o, e.data);
          end
        end
        if (rd_valid_o) begin
          if (rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rd_valid got %h exp no pulse", rd_data_o);
          end else begin
            chk("rd_data", rd_data_o, rd_q.pop_front());
          end
        end
        if (err_o) err_count++;
      end
      prev_stb   = stb_o;
      prev_pulse = wr_done_o | rd_valid_o;
    end
  end

  initial begin
    bit viol;
    bit seen;
    rst = 1'b1;
    initialized_i = 1'b0;
    wr_req_i = 1'b0;
    rd_req_i = 1'b0;
    wr_data_i = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_cyc", cyc_o, 0);
    chk("rst_stb", stb_o, 0);
    chk("rst_we", we_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_rd_data", rd_data_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_pulses", {err_o, wr_done_o, rd_valid_o}, 0);
    rst = 1'b0;

    // Calibration gate
    wr_data_i = A1;
    wr_req_i  = 1'b1;
    viol = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (cyc_o) viol = 1'b1;
    end
    chk("init_wait_no_cyc", viol, 0);
    exp_bus(1, 0, A1);
    initialized_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("init_stb_latency", stb_o, 1);
    do_write(A1, 100);
    chk("level_after_w1", level_o, 1);

    // Three writes then three reads in order
    exp_bus(1, 1, A2); do_write(A2, 100);
    exp_bus(1, 2, A3); do_write(A3, 100);
    chk("level_after_w3", level_o, 3);
    exp_bus(0, 0, '0); rd_q.push_back(A1); do_read(100);
    exp_bus(0, 1, '0); rd_q.push_back(A2); do_read(100);
    exp_bus(0, 2, '0); rd_q.push_back(A3); do_read(100);
    chk("level_after_r3", level_o, 0);
    chk("empty_after_r3", empty_o, 1);

    // Reset during an unacked write discards everything
    no_ack = 1'b1;
    exp_bus(1, 3, X0);
    wr_data_i = X0;
    wr_req_i  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stb_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("midrst_stb_seen", seen, 1);
    rst = 1'b1;
    wr_req_i = 1'b0;
    @(negedge clk);
    chk("midrst_cyc_drop", {cyc_o, stb_o}, 0);
    chk("midrst_level", level_o, 0);
    rst = 1'b0;
    no_ack = 1'b0;

    // Fill the ring, then hold a write while full
    exp_bus(1, 0, B0); do_write(B0, 100);
    exp_bus(1, 1, B1); do_write(B1, 100);
    exp_bus(1, 2, B2); do_write(B2, 100);
    exp_bus(1, 3, B3); do_write(B3, 100);
    chk("level_full", level_o, 4);
    chk("full_flag", full_o, 1);
    wr_data_i = B4;
    wr_req_i  = 1'b1;
    repeat (20) @(negedge clk);
    chk("full_hold", full_o, 1);
    exp_bus(0, 0, '0); rd_q.push_back(B0);
    exp_bus(1, 0, B4);
    fork
      do_read(100);
      do_write(B4, 100);
    join
    chk("level_after_wrap", level_o, 4);

    // Round robin with level 2
    exp_bus(0, 1, '0); rd_q.push_back(B1); do_read(100);
    exp_bus(0, 2, '0); rd_q.push_back(B2); do_read(100);
    chk("level_before_rr", level_o, 2);
    exp_bus(1, 1, C0);
    exp_bus(0, 3, '0); rd_q.push_back(B3);
    exp_bus(1, 2, C1);
    exp_bus(0, 0, '0); rd_q.push_back(B4);
    fork
      begin do_write(C0, 100); do_write(C1, 100); end
      begin do_read(100); do_read(100); end
    join
    chk("level_after_rr", level_o, 2);

    // Read while empty waits for a write
    exp_bus(0, 1, '0); rd_q.push_back(C0); do_read(100);
    exp_bus(0, 2, '0); rd_q.push_back(C1); do_read(100);
    chk("empty_before_wait", empty_o, 1);
    rd_req_i = 1'b1;
    repeat (20) @(negedge clk);
    exp_bus(1, 3, D0);
    exp_bus(0, 3, '0); rd_q.push_back(D0);
    fork
      do_read(200);
      do_write(D0, 100);
    join
    chk("level_after_empty_rd", level_o, 0);

    // Missing ack
    no_ack = 1'b1;
    exp_bus(1, 0, E0);
`ifdef DRAM_RING_SCHED_TIMEOUT_EN
    exp_bus(1, 0, E0);
`endif
    fork
      do_write(E0, 2000);
      begin
`ifdef DRAM_RING_SCHED_TIMEOUT_EN
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (err_o) begin
            seen = 1'b1;
            break;
          end
        end
        chk("timeout_err_seen", seen, 1);
        chk("timeout_level", level_o, 0);
        chk("timeout_no_done", wr_done_o, 0);
`else
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (cyc_o) begin
            seen = 1'b1;
            break;
          end
        end
        chk("hang_cyc_seen", seen, 1);
        viol = 1'b0;
        repeat (1000) begin
          @(negedge clk);
          if (!cyc_o || !stb_o || err_o) viol = 1'b1;
        end
        chk("hang_cyc_held", viol, 0);
`endif
        no_ack = 1'b0;
      end
    join
`ifdef DRAM_RING_SCHED_TIMEOUT_EN
    chk("err_pulse_count", err_count, 1);
`else
    chk("err_pulse_count", err_count, 0);
`endif
    chk("level_after_timeout", level_o, 1);

    repeat (5) @(negedge clk);
    chk("bus_q_drained", bus_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL global_timeout got running exp finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
